gate_truth_scanner: RTL

Sequential stimulus and capture stage wrapped around the basic two-input gate block (AND, OR, NOT a, NOT b, NAND, NOR, XOR, XNOR).
- Upstream side: on `start`, drives all four (a,b) combinations into the gate block's inputs.
- Downstream side: samples the gate block's eight outputs for each combination after a settle time and packs them into a 32-bit truth table.
- Optionally checks the table against a golden value and reports pass and per-vector mismatches.

---
 rtl/gate_truth_scanner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gate_truth_scanner.sv
// Drives all four (a,b) combinations into a two-input gate block and packs the sampled
// outputs into a 32-bit truth table. Define GATE_CHECK_EN to enable the golden comparison.
module gate_truth_scanner #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [31:0] EXPECTED      = 32'h835A56BC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a_out,
   output logic        b_out,
   input  logic [7:0]  y_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] table_out,
   output logic        pass,
   output logic [3:0]  fail_mask
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DONE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   state_t      state_q;
   logic [1:0]  vec_q;
   logic [7:0]  cnt_q;
   logic        a_q;
   logic        b_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] table_q;
   logic [31:0] table_d;
   logic        sample;
   logic        accept;
   logic        finish;

   // table_d already holds the byte being captured this edge, so the final
   // comparison sees the complete table on the DRIVE->DONE edge
   always_comb begin
      sample  = (cnt_q == CNT_LAST);
      accept  = (state_q == IDLE) && start;
      finish  = (state_q == DRIVE) && sample && (vec_q == 2'd3);
      table_d = table_q;
      table_d[8*vec_q +: 8] = y_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         table_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               a_q    <= 1'b0;
               b_q    <= 1'b0;
               done_q <= 1'b0;
               if (start) begin
                  state_q <= DRIVE;
                  vec_q   <= '0;
                  cnt_q   <= '0;
                  table_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            DRIVE: begin
               if (sample) begin
                  table_q <= table_d;
                  cnt_q   <= '0;
                  if (vec_q == 2'd3) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     a_q     <= 1'b0;
                     b_q     <= 1'b0;
                  end else begin
                     vec_q      <= vec_q + 2'd1;
                     {a_q, b_q} <= vec_q + 2'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign table_out = table_q;

`ifdef GATE_CHECK_EN
   logic       pass_q;
   logic [3:0] fail_q;
   logic [3:0] mism_d;

   always_comb begin
      mism_d = '0;
      for (int unsigned v = 0; v < 4; v++) begin
         mism_d[v] = (table_d[8*v +: 8] != EXPECTED[8*v +: 8]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_q <= 1'b0;
         fail_q <= '0;
      end else if (accept) begin
         pass_q <= 1'b0;
         fail_q <= '0;
      end else if (finish) begin
         pass_q <= (table_d == EXPECTED);
         fail_q <= mism_d;
      end
   end

   assign pass      = pass_q;
   assign fail_mask = fail_q;
`else
   logic unused_check;
   assign unused_check = ^{EXPECTED, accept, finish};
   assign pass         = 1'b0;
   assign fail_mask    = '0;
`endif

endmodule
